mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  Parametrised RV32I MEM stage with integrated load/store unit and MEM/WB pipeline register.
//  Supports byte, halfword and word loads and stores (LB/LH/LW/LBU/LHU, SB/SH/SW).
//  Detects misaligned accesses and supports configurable memory wait states via a busy/stall handshake.
//  Sits between the EX/MEM register and the WB stage; drives the hazard unit via mem_busy.
// PARAMETERS
//  DEPTH_WORDS  1024  data memory depth in 32-bit words (power of two)
//  ADDR_W       $clog2(DEPTH_WORDS)  word-index width (derived, not overridden)
//  WAIT_STATES  0     extra cycles per memory access (0..15)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   synchronous reset, active-low
//  in_valid       in   1   EX/MEM slot holds a valid instruction
//  alu_result     in   32  byte address for memory ops; passthrough result otherwise
//  rs2_data       in   32  store data (low bytes used for SB/SH)
//  funct3         in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  MemRead        in   1   load instruction
//  MemWrite       in   1   store instruction
//  RegWrite       in   1   instruction writes rd
//  rd_addr        in   5   destination register
//  flush          in   1   kill the instruction currently in this stage
//  wb_valid       out  1   MEM/WB slot valid
//  wb_data        out  32  load data (extended) or alu_result passthrough
//  wb_rd          out  5   registered rd_addr
//  wb_RegWrite    out  1   registered RegWrite, gated by exception/flush
//  mem_busy       out  1   stage cannot accept a new instruction; upstream must hold inputs
//  misaligned_exc out  1   one-cycle pulse alongside wb_valid for a misaligned access
//  exc_addr       out  32  faulting address; valid when misaligned_exc=1
// BEHAVIOUR
//  - Reset (reset==0 at posedge): FSM to IDLE, wait counter 0, every output 0. Memory contents are not reset.
//  - Word index = alu_result[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
//  - FSM states: IDLE, WAIT.
//    - In IDLE, an instruction with in_valid=1 is accepted every cycle.
//    - A non-memory instruction, or any access with WAIT_STATES=0, completes at the next edge (latency 1).
//    - A memory op with WAIT_STATES>0 moves to WAIT, loads the counter with WAIT_STATES, and drives mem_busy=1.
//    - In WAIT, the counter decrements each cycle; on the cycle it reaches 0, the access completes and the FSM returns to IDLE.
//    - Total latency is 1+WAIT_STATES cycles.
//    - mem_busy is combinational: high whenever the FSM is in WAIT. It is low in IDLE.
//    - Inputs presented while mem_busy=1 are ignored; upstream holds them stable.
//  - Store commit:
//    - The write happens only at the completing edge.
//    - SB writes one byte lane selected by addr[1:0] from rs2_data[7:0].
//    - SH writes lanes {addr[1],0} and {addr[1],1} from rs2_data[15:0].
//    - SW writes all four lanes.
//    - Byte lane 0 is the least significant byte (little-endian).
//  - Load:
//    - The word is read at the completing edge; data is pre-write (read-before-write within the same access).
//    - The lane is selected by addr[1:0].
//    - B/H are sign-extended; BU/HU are zero-extended.
//    - A load issued the cycle after a store to the same word sees the new data.
//  - Alignment:
//    - Misaligned means H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
//    - A misaligned access performs no memory write, forces wb_RegWrite=0, pulses misaligned_exc, sets exc_addr=alu_result, and still takes the full latency.
//  - MemRead and MemWrite both high: the op is treated as a store and wb_RegWrite is forced to 0.
//  - Unlisted funct3 (011, 110, 111): treated as a word access.
//  - Flush:
//    - Flush in IDLE: the next wb_valid is 0 and no write occurs.
//    - Flush in WAIT: the access is aborted, the FSM returns to IDLE next cycle with no write, wb_valid=0, and no exception.
//  - Completion: wb_valid=1 for exactly one cycle per accepted, unflushed instruction. In all other cycles wb_valid=0 and wb_RegWrite=0.
//  - Reset asserted during WAIT: access aborted, no memory write, state as for reset.
// TESTING
//  1. SW 0xDEADBEEF @0x10; LW @0x10 -> 0xDEADBEEF; LB @0x13 -> 0xFFFFFFDE; LBU @0x13 -> 0x000000DE; LH @0x12 -> 0xFFFFDEAD.
//  2. SB rs2=0x55 @0x11, then LW @0x10 -> 0xDEAD55EF; SH rs2=0x1234 @0x12, then LW -> 0x123455EF.
//  3. LW @0x0E -> misaligned_exc=1, exc_addr=0x0E, wb_RegWrite=0; SW @0x11 -> memory word 0x10 unchanged.
//  4. WAIT_STATES=2: LW issued at cycle 0 -> mem_busy=1 in cycles 1-2, wb_valid=1 with data in cycle 3; held inputs not re-executed.
//  5. WAIT_STATES=2: SW issued, flush in cycle 1 -> no write (read-back returns old value), wb_valid stays 0.
//  6. Reset during WAIT of an SW -> all outputs 0, FSM IDLE, target word unchanged; next LW completes normally.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// RV32I MEM stage: load/store unit over a byte-lane data memory with optional wait
// states, misalignment detection and the MEM/WB pipeline register.
module mem_stage_lsu #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] alu_result,
    input  logic [31:0] rs2_data,
    input  logic [2:0]  funct3,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic        RegWrite,
    input  logic [4:0]  rd_addr,
    input  logic        flush,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_RegWrite,
    output logic        mem_busy,
    output logic        misaligned_exc,
    output logic [31:0] exc_addr
);
    localparam int unsigned ADDR_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned XLEN   = 32;

    typedef enum logic {IDLE, WAIT} state_t;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
        logic [2:0]      funct3;
        logic            rd_en;
        logic            wr_en;
        logic            reg_wr;
        logic [4:0]      rd;
    } req_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    req_t             req_in, req_q, req_d, req;
    logic             complete;

    logic [XLEN-1:0]  mem_q [DEPTH_WORDS];

    logic [ADDR_W-1:0] idx;
    logic [1:0]        off;
    logic              mem_op, is_load, sz_byte, sz_half, mis, wr_commit;
    logic [3:0]        be;
    logic [XLEN-1:0]   wlanes, rword, load_val, wb_data_d;
    logic [15:0]       rshift;

    logic              wb_valid_q, wb_regwrite_q, exc_q;
    logic [XLEN-1:0]   wb_data_q, exc_addr_q;
    logic [4:0]        wb_rd_q;

    assign req_in = '{addr: alu_result, wdata: rs2_data, funct3: funct3, rd_en: MemRead,
                      wr_en: MemWrite, reg_wr: RegWrite, rd: rd_addr};

    // While waiting, the captured request drives the datapath; upstream inputs are ignored.
    assign req = (state_q == WAIT) ? req_q : req_in;

    // Access decode: size, alignment, byte enables and lane-replicated store data.
    always_comb begin
        idx     = req.addr[ADDR_W+1:2];
        off     = req.addr[1:0];
        mem_op  = req.rd_en | req.wr_en;
        is_load = req.rd_en & ~req.wr_en;
        sz_byte = (req.funct3[1:0] == 2'b00);
        sz_half = (req.funct3[1:0] == 2'b01);
        mis     = mem_op & ((sz_half & off[0]) | (~sz_byte & ~sz_half & (off != 2'b00)));
        if (sz_byte) begin
            be     = 4'b0001 << off;
            wlanes = {4{req.wdata[7:0]}};
        end else if (sz_half) begin
            be     = off[1] ? 4'b1100 : 4'b0011;
            wlanes = {2{req.wdata[15:0]}};
        end else begin
            be     = 4'b1111;
            wlanes = req.wdata;
        end
    end

    // Load path reads the pre-write word and extends the selected lane.
    always_comb begin
        rword  = mem_q[idx];
        rshift = 16'(rword >> {off, 3'b000});
        if (sz_byte) begin
            load_val = req.funct3[2] ? {24'b0, rshift[7:0]} : {{24{rshift[7]}}, rshift[7:0]};
        end else if (sz_half) begin
            load_val = req.funct3[2] ? {16'b0, rshift} : {{16{rshift[15]}}, rshift};
        end else begin
            load_val = rword;
        end
        wb_data_d = is_load ? load_val : req.addr;
    end

    // Next-state logic: accept in IDLE, count down wait states, abort on flush.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        req_d    = req_q;
        complete = 1'b0;
        mem_busy = 1'b0;
        case (state_q)
            IDLE: begin
                if (in_valid && !flush) begin
                    if (mem_op && (WAIT_STATES != 0)) begin
                        state_d = WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                        req_d   = req_in;
                    end else begin
                        complete = 1'b1;
                    end
                end
            end
            WAIT: begin
                mem_busy = 1'b1;
                if (flush) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(1)) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign wr_commit = complete & req.wr_en & ~mis;

    always_ff @(posedge clk) begin
        if (reset && wr_commit) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem_q[idx][8*i +: 8] <= wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            req_q         <= '0;
            wb_valid_q    <= 1'b0;
            wb_regwrite_q <= 1'b0;
            exc_q         <= 1'b0;
            wb_data_q     <= '0;
            exc_addr_q    <= '0;
            wb_rd_q       <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            req_q         <= req_d;
            wb_valid_q    <= complete;
            wb_regwrite_q <= complete & req.reg_wr & ~mis & ~(req.rd_en & req.wr_en);
            exc_q         <= complete & mis;
            exc_addr_q    <= (complete && mis) ? req.addr : '0;
            if (complete) begin
                wb_data_q <= wb_data_d;
                wb_rd_q   <= req.rd;
            end
        end
    end

    assign wb_valid       = wb_valid_q;
    assign wb_data        = wb_data_q;
    assign wb_rd          = wb_rd_q;
    assign wb_RegWrite    = wb_regwrite_q;
    assign misaligned_exc = exc_q;
    assign exc_addr       = exc_addr_q;

endmodule
